// File: rtl/conway_pkg.sv
// -----------------------------------------------------------------------------
// conway_pkg
//   Shared types and helpers for the Game of Life array and its readout.
//
//   reader_state_t : readout FSM states (IDLE, SEND, DONE)
//   cell_index()   : flattened bit position of cell (r,c) on a board that is
//                    `cols` cells wide; cell (r,c) lives at bit r*cols+c.
// -----------------------------------------------------------------------------
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } reader_state_t;

    function automatic int unsigned cell_index(
        input int unsigned r,
        input int unsigned c,
        input int unsigned cols
    );
        return r * cols + c;
    endfunction

endpackage : conway_pkg

// File: rtl/conway_row_popcount.sv
// -----------------------------------------------------------------------------
// conway_row_popcount
//   Counts the live cells in one board row. It exists only in builds that
//   define CONWAY_READER_POPCOUNT_EN, where the board reader uses it to total
//   the population of each frame.
//
//   Parameters : COLS  - row width in cells
//   Ports      : row   - one row of cell states, bit c = column c
//                count - number of set bits in row
// -----------------------------------------------------------------------------
`ifdef CONWAY_READER_POPCOUNT_EN
module conway_row_popcount #(
    parameter int COLS = 8
) (
    input  logic [COLS-1:0]            row,
    output logic [$clog2(COLS+1)-1:0]  count
);

    localparam int CNT_W = $clog2(COLS + 1);

    always_comb begin
        count = '0;
        for (int c = 0; c < COLS; c++) begin
            count = count + CNT_W'(row[c]);
        end
    end

endmodule : conway_row_popcount
`endif

// File: rtl/conway_board_reader.sv
// -----------------------------------------------------------------------------
// conway_board_reader
//   Readout end of the Game of Life array. On a start request in IDLE the whole
//   flattened board is copied into a shadow register; the shadow copy is then
//   streamed out one row per beat over a valid/ready handshake. Because only
//   the shadow copy is streamed, the array may keep stepping while a frame
//   drains.
//
//   Optional feature (macro CONWAY_READER_POPCOUNT_EN): adds a `population`
//   output holding the live-cell count of the frame, final from the done pulse
//   until the next capture.
//
//   Parameters : ROWS (>= 2), COLS (>= 1)
//   Ports      : clk        - rising-edge clock
//                rst        - asynchronous active-low reset
//                board_q    - live cell states, cell (r,c) at bit r*COLS+c
//                start      - frame request, sampled only in IDLE
//                busy       - high from capture until the cycle after the last
//                             beat is accepted
//                row_valid  - row beat valid
//                row_ready  - downstream accepts the beat
//                row_data   - shadow row row_idx, bit c = cell (row_idx,c)
//                row_idx    - index of the row currently presented
//                sof / eof  - first / last row marker, qualified by row_valid
//                done       - one-cycle pulse after the last beat is accepted
//                population - (optional) live-cell count of the frame
// -----------------------------------------------------------------------------
module conway_board_reader
    import conway_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROWS*COLS-1:0]      board_q,
    input  logic                      start,
    output logic                      busy,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [COLS-1:0]           row_data,
    output logic [$clog2(ROWS)-1:0]   row_idx,
    output logic                      sof,
    output logic                      eof,
    output logic                      done
`ifdef CONWAY_READER_POPCOUNT_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] population
`endif
);

    localparam int                IDX_W    = $clog2(ROWS);
    localparam int                BIT_W    = $clog2(ROWS * COLS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);

    reader_state_t             state_q;
    reader_state_t             state_d;
    logic [ROWS*COLS-1:0]      shadow_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      capture;
    logic                      accept;
    logic                      last_row;

    assign capture  = (state_q == IDLE) && start;
    assign accept   = row_valid && row_ready;
    assign last_row = (idx_q == LAST_IDX);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)               state_d = SEND;
            SEND:    if (accept && last_row)  state_d = DONE;
            DONE:                             state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the shadow board is an ordinary register bank, not a RAM, so it is
    // cleared on reset like any other flop and row_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            idx_q    <= '0;
        end else if (capture) begin
            shadow_q <= board_q;
            idx_q    <= '0;
        end else if (accept && !last_row) begin
            // Holding at LAST_IDX on the final beat keeps row_idx saturated;
            // it only returns to 0 at the next capture.
            idx_q <= idx_q + 1'b1;
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops row_valid, busy and done immediately.
    assign row_valid = (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign row_idx   = idx_q;
    assign sof       = row_valid && (idx_q == '0);
    assign eof       = row_valid && last_row;

    always_comb begin
        logic [BIT_W-1:0] bit_sel;
        row_data = '0;
        bit_sel  = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            bit_sel     = BIT_W'(cell_index(32'(idx_q), c, COLS));
            row_data[c] = shadow_q[bit_sel];
        end
    end

`ifdef CONWAY_READER_POPCOUNT_EN
    localparam int POP_W = $clog2(ROWS * COLS + 1);
    localparam int CNT_W = $clog2(COLS + 1);

    logic [CNT_W-1:0] row_count;
    logic [POP_W-1:0] pop_q;

    conway_row_popcount #(
        .COLS (COLS)
    ) u_row_popcount (
        .row   (row_data),
        .count (row_count)
    );

    // Counts are added on the handshake cycle, so a stalled beat is counted
    // exactly once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_q <= '0;
        end else if (capture) begin
            pop_q <= '0;
        end else if (accept) begin
            pop_q <= pop_q + POP_W'(row_count);
        end
    end

    assign population = pop_q;
`endif

endmodule : conway_board_reader

// File: tb/tb_conway_board_reader.sv
// -----------------------------------------------------------------------------
// tb_conway_board_reader
//   Scoreboard bench for conway_board_reader (ROWS=8, COLS=8). Directed frames
//   push their expected beats into a queue; a negedge monitor pops and compares
//   on every accepted beat, checks that stalled beats hold, and checks that
//   done pulses exactly one cycle after the last accepted beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conway_board_reader;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                row_ready = 1'b0;
    logic [ROWS*COLS-1:0] board_q = '0;
    logic                busy;
    logic                row_valid;
    logic [COLS-1:0]     row_data;
    logic [2:0]          row_idx;
    logic                sof;
    logic                eof;
    logic                done;
`ifdef CONWAY_READER_POPCOUNT_EN
    logic [6:0]          population;
`endif

    always #5 clk = ~clk;

    conway_board_reader #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .board_q    (board_q),
        .start      (start),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .sof        (sof),
        .eof        (eof),
        .done       (done)
`ifdef CONWAY_READER_POPCOUNT_EN
        ,
        .population (population)
`endif
    );

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    beat_t exp_q[$];
    int    pop_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected beats of a frame; rows come straight from the packed
    // board constant {row7,...,row0}. Only complete frames carry a population.
    task automatic push_frame(input logic [63:0] b, input int pop, input int nbeats);
        beat_t e;
        for (int r = 0; r < nbeats; r++) begin
            e.idx  = 3'(r);
            e.data = b[r*8 +: 8];
            e.sof  = (r == 0);
            e.eof  = (r == 7);
            exp_q.push_back(e);
        end
        if (nbeats == 8) pop_q.push_back(pop);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", row_valid, 1'b1);
        check("first_idx", row_idx, 3'd0);
        check("busy_rise", busy, 1'b1);
    endtask

    // mode 0: ready=1; 1: ready 1,0,0,1,...; 2: ready=1 and board inverted each
    // cycle; 3: ready=1 and start pulsed on beats 2 and 5.
    task automatic run_until_done(input int mode, input int budget, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            case (mode)
                1:       row_ready = (cycles % 4 == 0) || (cycles % 4 == 3);
                2:       begin row_ready = 1'b1; board_q = ~board_q; end
                3:       begin row_ready = 1'b1; start = row_valid && (row_idx == 3'd2 || row_idx == 3'd5); end
                default: row_ready = 1'b1;
            endcase
            tick();
            cycles++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done expected=done within %0d cycles", budget);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic       prev_stall = 1'b0;
    logic       prev_last  = 1'b0;
    logic [2:0] prev_idx   = '0;
    logic [7:0] prev_data  = '0;
    beat_t      mon_e;
    logic       mon_last;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_last  = 1'b0;
        end else begin
            check("done_timing", done, prev_last);
`ifdef CONWAY_READER_POPCOUNT_EN
            if (done) begin
                if (pop_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL population_unexpected actual=%0d expected=no frame", population);
                end else begin
                    check("population", population, 64'(pop_q.pop_front()));
                end
            end
`endif
            if (!row_valid) check("sof_eof_idle", {sof, eof}, 2'b00);
            if (prev_stall) begin
                check("hold_valid", row_valid, 1'b1);
                check("hold_idx", row_idx, prev_idx);
                check("hold_data", row_data, prev_data);
            end
            mon_last = 1'b0;
            if (row_valid && row_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=idx%0d/%h expected=no beat", row_idx, row_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_idx", row_idx, mon_e.idx);
                    check("beat_data", row_data, mon_e.data);
                    check("beat_sof", sof, mon_e.sof);
                    check("beat_eof", eof, mon_e.eof);
                    mon_last = mon_e.eof;
                end
            end
            prev_last  = mon_last;
            prev_stall = row_valid && !row_ready;
            prev_idx   = row_idx;
            prev_data  = row_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=bench finished");
        $fatal(1);
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int   cycles;
        logic found;

        // Reset held 3 cycles, then 10 idle cycles with start=0.
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", row_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", {row_idx, row_data}, 11'd0);
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_valid", row_valid, 1'b0);
            check("idle_done", done, 1'b0);
        end

        // Glider in rows 0-2, full-rate readout: 8 beats then done.
        tick();
        board_q = 64'h0000_0000_0007_0402;
        push_frame(board_q, 5, 8);
        start_frame();
        run_until_done(0, 40, cycles);
        check("glider_latency", cycles, 8);
        tick();
        check("glider_idle_busy", busy, 1'b0);

        // Backpressure with ready 1,0,0,1,...: beats accepted on cycles
        // 0,3,4,7,8,11,12,15, so done follows 16 cycles after start.
        board_q = 64'h3CA5_00FF_1824_4281;
        push_frame(board_q, 24, 8);
        start_frame();
        run_until_done(1, 60, cycles);
        check("bp_latency", cycles, 16);
        tick();

        // Snapshot isolation: board inverted every cycle after capture.
        board_q = 64'h0807_0605_0403_0201;
        push_frame(board_q, 13, 8);
        start_frame();
        run_until_done(2, 40, cycles);
        check("snap_latency", cycles, 8);
        board_q = '0;
        tick();

        // start on beats 2 and 5 and in DONE: no restart.
        board_q = 64'hF0E0_C080_0103_070F;
        push_frame(board_q, 20, 8);
        start_frame();
        run_until_done(3, 40, cycles);
        check("swb_latency", cycles, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("swb_no_restart_busy", busy, 1'b0);
            check("swb_no_restart_valid", row_valid, 1'b0);
            tick();
        end

        // Reset during beat 4: beats 0-3 accepted, no done afterwards.
        board_q = 64'h1122_3344_5566_7788;
        push_frame(board_q, 0, 4);
        row_ready = 1'b1;
        start_frame();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (row_valid && row_idx == 3'd4) found = 1'b1;
            else tick();
        end
        check("abort_reached_beat4", found, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_valid_drop", row_valid, 1'b0);
        check("abort_busy_drop", busy, 1'b0);
        check("abort_no_done", done, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        check("abort_beats_left", exp_q.size(), 0);
        repeat (3) tick();

        // Fresh frame after the abort streams from row 0.
        push_frame(board_q, 26, 8);
        start_frame();
        run_until_done(0, 40, cycles);
        check("restart_latency", cycles, 8);
        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_conway_board_reader
